// File: rtl/data_mem_responder.sv
// Data-memory slave for the MIPS core's active-low SRAM port.
// Self-clears after reset, accepts a preload stream, then serves combinational reads and clocked writes.
module data_mem_responder #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [AW-1:0]    A,
  input  logic [DW-1:0]    Data2Mem,
  output logic [DW-1:0]    ReadDataMem,
  input  logic             ld_valid,
  input  logic [DW-1:0]    ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

  state_t        state_reg;
  logic [AW-1:0] clr_ptr_reg;
  logic [AW-1:0] ld_ptr_reg;
  logic [DW-1:0] mem [0:2**AW-1];

  logic          core_rd;
  logic          core_wr;
  logic          ld_xfer;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  assign busy     = (state_reg != ST_RUN);
  assign ld_ready = (state_reg == ST_LOAD);
  assign ld_xfer  = ld_ready && ld_valid;

  // A write takes priority over a read when WEN and OEN are both low.
  assign core_wr = !busy && !CEN && !WEN;
  assign core_rd = !busy && !CEN && !OEN && WEN;

  // One shared write port, steered by the phase we are in.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = clr_ptr_reg;
    mem_wdata = '0;
    case (state_reg)
      ST_CLEAR: mem_we = 1'b1;
      ST_LOAD: begin
        mem_we    = ld_xfer;
        mem_addr  = ld_ptr_reg;
        mem_wdata = ld_data;
      end
      ST_RUN: begin
        mem_we    = core_wr;
        mem_addr  = A;
        mem_wdata = Data2Mem;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign ReadDataMem = core_rd ? mem[A] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
      ld_ptr_reg  <= '0;
      proto_err   <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == '1) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          // The top address ends the preload even without ld_last; no wrap.
          if (ld_xfer) begin
            ld_ptr_reg <= ld_ptr_reg + 1'b1;
            if (ld_last || ld_ptr_reg == '1) state_reg <= ST_RUN;
          end
        end
        ST_RUN: state_reg <= ST_RUN;
        default: state_reg <= ST_CLEAR;
      endcase
      if (core_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (core_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      if (core_wr && !OEN) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-plus-random bench for data_mem_responder, checked against a behavioural memory model.
// Counters are built narrow so saturation is reached within a short run.
module tb_data_mem_responder;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int CW    = 5;
  localparam int DEPTH = 2**AW;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          CEN = 1'b1, WEN = 1'b1, OEN = 1'b1;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] Data2Mem = '0;
  logic [DW-1:0] ReadDataMem;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready, busy, proto_err;
  logic [CW-1:0] rd_cnt, wr_cnt;

  data_mem_responder #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy),
    .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_mem [DEPTH];
  int          m_rd, m_wr;
  bit          m_err;
  logic [31:0] ld_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_core();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle; effects must show before any clock edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("rst_busy", busy, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_rd_cnt", rd_cnt, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    foreach (model_mem[i]) model_mem[i] = '0;
    m_rd = 0; m_wr = 0; m_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    $display("reset applied");
  endtask

  // 128 cycles of clearing with random core and preload traffic that must be ignored.
  task automatic clear_phase();
    for (int i = 0; i < DEPTH; i++) begin
      CEN = 1'($urandom); WEN = 1'($urandom); OEN = 1'($urandom);
      A = AW'($urandom); Data2Mem = $urandom;
      ld_valid = 1'($urandom); ld_data = $urandom; ld_last = 1'($urandom);
      @(negedge clk);
      check("clr_busy", busy, 1);
      check("clr_ld_ready", ld_ready, 0);
      check("clr_rdata", ReadDataMem, 0);
      @(posedge clk); #1;
    end
    idle_core(); ld_valid = 1'b0; ld_last = 1'b0;
    check("clr_done_ld_ready", ld_ready, 1);
    check("clr_done_busy", busy, 1);
    check("clr_done_rd_cnt", rd_cnt, 0);
    check("clr_done_wr_cnt", wr_cnt, 0);
    $display("clear pass done");
  endtask

  // Push up to n_xfer words of ld_q; preload ends on ld_last or on the top address.
  task automatic preload(input int n_xfer, input int last_idx, input bit bubbles, input bit exp_done);
    int ptr = 0;
    int guard = 0;
    bit done = 0;
    while (!done && ptr < n_xfer && guard < 2000) begin
      guard++;
      ld_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data  = ld_q[ptr];
      ld_last  = (ptr == last_idx);
      @(negedge clk);
      check("ld_ready_in_load", ld_ready, 1);
      @(posedge clk);
      if (ld_valid) begin
        model_mem[ptr] = ld_data;
        $display("preload addr=%0d data=%h last=%0b", ptr, ld_data, ld_last);
        if (ld_last || ptr == DEPTH - 1) done = 1;
        ptr++;
      end
      #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("preload_done", done, exp_done);
    check("preload_busy", busy, exp_done ? 0 : 1);
    check("preload_ld_ready", ld_ready, exp_done ? 0 : 1);
  endtask

  task automatic core(input logic cen, input logic wen, input logic oen,
                      input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
    @(negedge clk);
    exp_rd = (!cen && !oen && wen) ? model_mem[a] : 32'h0;
    check("read_data", ReadDataMem, exp_rd);
    @(posedge clk);
    if (!cen && !wen) begin
      model_mem[a] = d;
      if (m_wr < MAXC) m_wr++;
      if (!oen) m_err = 1;
    end else if (!cen && !oen) begin
      if (m_rd < MAXC) m_rd++;
    end
    #1;
    check("rd_cnt", rd_cnt, m_rd);
    check("wr_cnt", wr_cnt, m_wr);
    check("proto_err", proto_err, m_err);
    check("run_busy", busy, 0);
    $display("core cen=%0b wen=%0b oen=%0b a=%0d d=%h rdata=%h rd=%0d wr=%0d err=%0b",
             cen, wen, oen, a, d, exp_rd, m_rd, m_wr, m_err);
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < DEPTH; a++) core(1'b0, 1'b1, 1'b0, AW'(a), $urandom);
  endtask

  initial begin
    // Reset, clear pass, then wait with ld_valid low
    do_reset();
    clear_phase();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wait_ld_ready", ld_ready, 1);
      check("wait_busy", busy, 1);
      @(posedge clk); #1;
    end

    // Three-word preload, last on the third
    ld_q = '{32'h11, 32'h22, 32'h33};
    preload(3, 2, 1'b0, 1'b1);
    core(1'b0, 1'b1, 1'b0, 7'd1, 32'h0);
    check("t2_word1", model_mem[1], 32'h22);
    core(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
    check("t2_rd_cnt", rd_cnt, 2);
    core(1'b0, 1'b1, 1'b0, 7'd100, 32'h0);

    // Write then read back on the next cycle
    core(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    core(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    check("t4_wr_cnt", wr_cnt, 1);

    // Write/read conflict: write wins, sticky error
    core(1'b0, 1'b0, 1'b0, 7'd9, 32'h7);
    core(1'b0, 1'b1, 1'b0, 7'd9, 32'h0);
    check("t5_proto_err", proto_err, 1);
    core(1'b1, 1'b0, 1'b0, 7'd9, 32'h55);

    // Random core traffic on a small address window, saturating both counters
    for (int i = 0; i < 300; i++)
      core(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
    check("sat_rd_cnt", rd_cnt, MAXC);
    check("sat_wr_cnt", wr_cnt, MAXC);

    // Reset from RUN, then a full-depth preload without ld_last
    do_reset();
    clear_phase();
    ld_q.delete();
    for (int i = 0; i < DEPTH; i++) ld_q.push_back($urandom);
    preload(DEPTH, -1, 1'b1, 1'b1);
    ld_valid = 1'b1; ld_data = 32'hBAD0BAD0; ld_last = 1'b1;
    sweep_reads();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("t3_last_word", model_mem[DEPTH-1], ld_q[DEPTH-1]);

    // Reset in the middle of a preload; earlier words must be cleared
    do_reset();
    clear_phase();
    ld_q = '{32'hA1A1A1A1, 32'hB2B2B2B2};
    preload(2, -1, 1'b0, 1'b0);
    do_reset();
    clear_phase();
    ld_q = '{32'hC3C3C3C3};
    preload(1, 0, 1'b0, 1'b1);
    sweep_reads();
    check("t6_word1_cleared", model_mem[1], 32'h0);

    idle_core();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
